// File: rtl/life_ctrl.sv
// Sequencer for a 4x4 life array: seed load handshake, write/step strobes,
// generation counting and automatic halt on extinction, still life or limit.
module life_ctrl #(
  parameter int unsigned STEP_PERIOD = 4,
  parameter int unsigned GEN_W       = 8,
  parameter int unsigned MAX_GEN     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [15:0]      load_data,
  output logic             load_ready,
  input  logic             run,
  input  logic             single,
  input  logic             stop,
  input  logic [15:0]      alive,
  output logic [15:0]      val,
  output logic             write_enb,
  output logic             step,
  output logic             busy,
  output logic [GEN_W-1:0] gen_count,
  output logic             halted,
  output logic [1:0]       halt_cause
);

  localparam int unsigned      CNT_W      = $clog2(STEP_PERIOD + 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(STEP_PERIOD - 3);
  localparam logic [GEN_W-1:0] GEN_LIMIT  = GEN_W'(MAX_GEN);

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, WAIT, STEP, CHECK, HALT} state_t;
  typedef enum logic {MODE_RUN, MODE_SINGLE} mode_t;

  state_t           state, state_nxt;
  mode_t            mode, mode_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       cause_nxt;
  logic [15:0]      snapshot;
  logic             accept;

  assign load_ready = (state == IDLE) || (state == HALT);
  assign busy       = !load_ready;
  assign halted     = (state == HALT);
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_nxt = state;
    mode_nxt  = mode;
    cnt_nxt   = cnt;
    cause_nxt = halt_cause;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = LOAD;
          mode_nxt  = MODE_RUN;
          cause_nxt = '0;
        end else if (single) begin
          state_nxt = STEP;
          mode_nxt  = MODE_SINGLE;
        end else if (run && !stop) begin
          state_nxt = WAIT;
          mode_nxt  = MODE_RUN;
          cnt_nxt   = CNT_RELOAD;
        end
      end
      LOAD:   state_nxt = SETTLE;
      SETTLE: state_nxt = IDLE;
      WAIT: begin
        if (stop || !run)   state_nxt = IDLE;
        else if (cnt == '0) state_nxt = STEP;
        else                cnt_nxt   = cnt - 1'b1;
      end
      STEP: state_nxt = CHECK;
      CHECK: begin
        // gen_count already holds the post-step value here
        if (alive == '0) begin
          state_nxt = HALT;
          cause_nxt = 2'b01;
        end else if (alive == snapshot) begin
          state_nxt = HALT;
          cause_nxt = 2'b10;
        end else if ((MAX_GEN != 0) && (gen_count == GEN_LIMIT)) begin
          state_nxt = HALT;
          cause_nxt = 2'b11;
        end else if ((mode == MODE_SINGLE) || stop || !run) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_RELOAD;
        end
      end
      HALT: begin
        if (accept) begin
          state_nxt = LOAD;
          mode_nxt  = MODE_RUN;
          cause_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mode       <= MODE_RUN;
      cnt        <= '0;
      snapshot   <= '0;
      val        <= '0;
      write_enb  <= 1'b0;
      step       <= 1'b0;
      gen_count  <= '0;
      halt_cause <= '0;
    end else begin
      state      <= state_nxt;
      mode       <= mode_nxt;
      cnt        <= cnt_nxt;
      halt_cause <= cause_nxt;
      write_enb  <= (state_nxt == LOAD);
      step       <= (state_nxt == STEP);
      if (state == STEP) snapshot <= alive;
      if (accept) begin
        val       <= load_data;
        gen_count <= '0;
      end else if ((state == STEP) && (gen_count != '1)) begin
        gen_count <= gen_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_life_ctrl.sv
// Bench for life_ctrl: behavioural 4x4 life array plus generation-level
// prediction of halt cause, generation count and final pattern.
module tb_life_ctrl;
  localparam int unsigned P  = 5;
  localparam int unsigned MG = 4;

  logic        clk = 1'b0;
  logic        reset, load_valid, run, single, stop;
  logic [15:0] load_data;
  logic        load_ready, write_enb, step, busy, halted;
  logic [15:0] alive, val;
  logic [7:0]  gen_count;
  logic [1:0]  halt_cause;
  logic [15:0] arr = '0;

  int n_checks = 0, n_pass = 0;

  life_ctrl #(.STEP_PERIOD(P), .GEN_W(8), .MAX_GEN(MG)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .run(run), .single(single), .stop(stop),
    .alive(alive), .val(val), .write_enb(write_enb), .step(step), .busy(busy),
    .gen_count(gen_count), .halted(halted), .halt_cause(halt_cause)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] life_next(input logic [15:0] g);
    logic [15:0] r;
    int n;
    r = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        n = 0;
        for (int di = -1; di <= 1; di++)
          for (int dj = -1; dj <= 1; dj++)
            if ((di != 0 || dj != 0) && i + di >= 0 && i + di < 4 && j + dj >= 0 && j + dj < 4)
              n += int'(g[4 * (i + di) + (j + dj)]);
        r[4 * i + j] = (n == 3) || (n == 2 && g[4 * i + j]);
      end
    return r;
  endfunction

  // Generation-level prediction of where a free run from seed s ends.
  function automatic void predict(input logic [15:0] s, output int gens,
                                  output logic [1:0] cause, output logic [15:0] fin);
    logic [15:0] cur, nxt;
    cur = s; gens = 0; cause = 2'b11; fin = s;
    for (int g = 1; g <= int'(MG); g++) begin
      nxt = life_next(cur);
      gens = g; fin = nxt;
      if (nxt == '0) begin cause = 2'b01; return; end
      if (nxt == cur) begin cause = 2'b10; return; end
      cur = nxt;
    end
  endfunction

  assign alive = arr;
  always @(posedge clk)
    if (write_enb) arr <= val;
    else if (step) arr <= life_next(arr);

  int          cyc = 0;
  int          step_times[$];
  logic [15:0] post_alive[$];
  int          adj_viol = 0, both_viol = 0, we_cnt = 0;
  logic        prev_step = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (prev_step) post_alive.push_back(alive);
    if (step) begin
      step_times.push_back(cyc);
      if (prev_step) adj_viol++;
    end
    if (step && write_enb) both_viol++;
    if (write_enb) we_cnt++;
    prev_step = step;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_free(input int max, output bit to);
    to = 1'b1;
    for (int i = 0; i < max; i++) begin
      tick();
      if (!busy) begin to = 1'b0; break; end
    end
  endtask

  task automatic wait_step(input int max, output bit to);
    to = 1'b1;
    for (int i = 0; i < max; i++) begin
      tick();
      if (step) begin to = 1'b0; break; end
    end
  endtask

  task automatic do_load(input logic [15:0] p);
    bit to;
    to = 1'b1;
    load_valid = 1'b1; load_data = p;
    for (int i = 0; i < 40; i++) begin
      if (load_ready) begin to = 1'b0; tick(); break; end
      tick();
    end
    load_valid = 1'b0;
    tick(); tick();
    n_checks++; if (to) $display("FAIL load_timeout got no load_ready want ready"); else n_pass++;
  endtask

  task automatic test_reset();
    n_checks++; if ({val, write_enb, step, gen_count, halted, halt_cause, busy} !== '0) $display("FAIL reset_outs got val=%h we=%b st=%b gen=%0d h=%b c=%b busy=%b want zeros", val, write_enb, step, gen_count, halted, halt_cause, busy); else n_pass++;
    n_checks++; if (load_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", load_ready); else n_pass++;
    reset = 1'b1;
    tick();
    n_checks++; if (load_ready !== 1'b1 || busy !== 1'b0) $display("FAIL reset_idle got ready=%b busy=%b want 1/0", load_ready, busy); else n_pass++;
  endtask

  task automatic test_load_extinct();
    load_valid = 1'b1; load_data = 16'h0001;
    tick(); load_valid = 1'b0;
    n_checks++; if (write_enb !== 1'b1 || val !== 16'h0001) $display("FAIL ld_we got we=%b val=%h want 1/0001", write_enb, val); else n_pass++;
    n_checks++; if (busy !== 1'b1 || load_ready !== 1'b0) $display("FAIL ld_busy got busy=%b ready=%b want 1/0", busy, load_ready); else n_pass++;
    tick();
    n_checks++; if (write_enb !== 1'b0 || alive !== 16'h0001 || load_ready !== 1'b0) $display("FAIL ld_settle got we=%b alive=%h ready=%b want 0/0001/0", write_enb, alive, load_ready); else n_pass++;
    tick();
    n_checks++; if (load_ready !== 1'b1) $display("FAIL ld_ready got %b want 1", load_ready); else n_pass++;
    single = 1'b1; tick(); single = 1'b0;
    n_checks++; if (step !== 1'b1) $display("FAIL sgl_step got %b want 1", step); else n_pass++;
    tick();
    n_checks++; if (step !== 1'b0 || gen_count !== 8'd1 || alive !== 16'h0000) $display("FAIL sgl_check got st=%b gen=%0d alive=%h want 0/1/0000", step, gen_count, alive); else n_pass++;
    tick();
    n_checks++; if (halted !== 1'b1 || halt_cause !== 2'b01 || load_ready !== 1'b1) $display("FAIL extinct got h=%b c=%b ready=%b want 1/01/1", halted, halt_cause, load_ready); else n_pass++;
  endtask

  task automatic test_single_blinker();
    do_load(16'h0070);
    n_checks++; if (halted !== 1'b0 || halt_cause !== 2'b00 || gen_count !== 8'd0) $display("FAIL blk_clear got h=%b c=%b gen=%0d want 0/00/0", halted, halt_cause, gen_count); else n_pass++;
    for (int k = 1; k <= 2; k++) begin
      single = 1'b1; tick(); single = 1'b0; tick(); tick();
      n_checks++; if (alive !== (k == 1 ? 16'h0222 : 16'h0070) || gen_count !== 8'(k)) $display("FAIL blk_gen%0d got alive=%h gen=%0d", k, alive, gen_count); else n_pass++;
      n_checks++; if (busy !== 1'b0 || halted !== 1'b0) $display("FAIL blk_idle%0d got busy=%b h=%b want 0/0", k, busy, halted); else n_pass++;
    end
  endtask

  task automatic test_still_life();
    bit to; int s0;
    do_load(16'h0660);
    s0 = step_times.size();
    run = 1'b1;
    wait_free(60, to);
    repeat (2 * P) tick();
    run = 1'b0;
    n_checks++; if (to) $display("FAIL still_timeout got busy want halt"); else n_pass++;
    n_checks++; if (step_times.size() - s0 !== 1) $display("FAIL still_steps got %0d want 1", step_times.size() - s0); else n_pass++;
    n_checks++; if (halted !== 1'b1 || halt_cause !== 2'b10 || gen_count !== 8'd1) $display("FAIL still_halt got h=%b c=%b gen=%0d want 1/10/1", halted, halt_cause, gen_count); else n_pass++;
    n_checks++; if (alive !== 16'h0660 || load_ready !== 1'b1) $display("FAIL still_alive got %h ready=%b want 0660/1", alive, load_ready); else n_pass++;
  endtask

  task automatic test_max_gen();
    bit to; int sb, ab, run_cyc;
    logic [15:0] exp_seq [4];
    exp_seq[0] = 16'hC813; exp_seq[1] = 16'hCC33; exp_seq[2] = 16'hC813; exp_seq[3] = 16'hCC33;
    do_load(16'hCC33);
    sb = step_times.size(); ab = post_alive.size();
    run = 1'b1; run_cyc = cyc;
    wait_free(100, to);
    run = 1'b0;
    n_checks++; if (to) $display("FAIL max_timeout got busy want halt"); else n_pass++;
    n_checks++; if (halted !== 1'b1 || halt_cause !== 2'b11 || gen_count !== 8'd4) $display("FAIL max_halt got h=%b c=%b gen=%0d want 1/11/4", halted, halt_cause, gen_count); else n_pass++;
    n_checks++; if (step_times.size() - sb !== 4 || post_alive.size() - ab !== 4) $display("FAIL max_nsteps got %0d want 4", step_times.size() - sb); else n_pass++;
    if (step_times.size() - sb == 4 && post_alive.size() - ab == 4) begin
      n_checks++; if (step_times[sb] - run_cyc !== int'(P) - 1) $display("FAIL max_first got %0d want %0d", step_times[sb] - run_cyc, P - 1); else n_pass++;
      for (int k = 0; k < 4; k++) begin
        n_checks++; if (post_alive[ab + k] !== exp_seq[k]) $display("FAIL max_seq%0d got %h want %h", k, post_alive[ab + k], exp_seq[k]); else n_pass++;
        if (k > 0) begin
          n_checks++; if (step_times[sb + k] - step_times[sb + k - 1] !== int'(P)) $display("FAIL max_gap%0d got %0d want %0d", k, step_times[sb + k] - step_times[sb + k - 1], P); else n_pass++;
        end
      end
    end
  endtask

  task automatic test_run_stop();
    bit to;
    do_load(16'h6186);
    run = 1'b1;
    wait_step(40, to);
    run = 1'b0;
    tick(); tick();
    n_checks++; if (to) $display("FAIL rs_timeout got no step want step"); else n_pass++;
    n_checks++; if (alive !== 16'h2664 || alive !== life_next(16'h6186)) $display("FAIL rs_alive got %h want 2664", alive); else n_pass++;
    n_checks++; if (busy !== 1'b0 || halted !== 1'b0 || gen_count !== 8'd1) $display("FAIL rs_idle got busy=%b h=%b gen=%0d want 0/0/1", busy, halted, gen_count); else n_pass++;
    do_load(16'h0070);
    n_checks++; if (gen_count !== 8'd0) $display("FAIL rs_reload got gen=%0d want 0", gen_count); else n_pass++;
  endtask

  task automatic test_busy_ignore();
    bit to; int we0;
    do_load(16'h0070);
    run = 1'b1;
    wait_step(40, to);
    tick(); tick();
    we0 = we_cnt;
    load_valid = 1'b1; load_data = 16'hFFFF; single = 1'b1;
    tick();
    load_valid = 1'b0; single = 1'b0; stop = 1'b1;
    tick();
    run = 1'b0; stop = 1'b0;
    tick();
    n_checks++; if (to) $display("FAIL bi_timeout got no step want step"); else n_pass++;
    n_checks++; if (val !== 16'h0070 || we_cnt !== we0) $display("FAIL bi_load got val=%h we+=%0d want 0070/0", val, we_cnt - we0); else n_pass++;
    n_checks++; if (busy !== 1'b0 || halted !== 1'b0 || gen_count !== 8'd1 || alive !== 16'h0222) $display("FAIL bi_stop got busy=%b h=%b gen=%0d alive=%h want 0/0/1/0222", busy, halted, gen_count, alive); else n_pass++;
  endtask

  task automatic test_run_single_together();
    bit to; int c;
    do_load(16'h0070);
    c = cyc;
    run = 1'b1; single = 1'b1;
    tick(); single = 1'b0;
    n_checks++; if (step !== 1'b1) $display("FAIL rsg_step got %b want 1", step); else n_pass++;
    tick(); tick();
    n_checks++; if (busy !== 1'b0 || gen_count !== 8'd1) $display("FAIL rsg_idle got busy=%b gen=%0d want 0/1", busy, gen_count); else n_pass++;
    wait_step(40, to);
    n_checks++; if (to || cyc !== c + int'(P) + 2) $display("FAIL rsg_runstart got cyc+%0d want +%0d", cyc - c, P + 2); else n_pass++;
    run = 1'b0;
    wait_free(10, to);
    n_checks++; if (to || gen_count !== 8'd2 || alive !== 16'h0070) $display("FAIL rsg_end got gen=%0d alive=%h want 2/0070", gen_count, alive); else n_pass++;
  endtask

  task automatic test_random();
    bit to; int gens, s0; logic [1:0] cause; logic [15:0] fin, seed, cur;
    for (int it = 0; it < 12; it++) begin
      seed = 16'($urandom);
      predict(seed, gens, cause, fin);
      do_load(seed);
      if ($urandom_range(0, 1) == 1) begin
        s0 = step_times.size();
        run = 1'b1;
        wait_free(80, to);
        run = 1'b0;
        n_checks++; if (to || step_times.size() - s0 !== gens) $display("FAIL rnd%0d_run got steps=%0d want %0d", it, step_times.size() - s0, gens); else n_pass++;
      end else begin
        cur = seed;
        for (int k = 0; k < int'(MG) + 2; k++) begin
          if (halted) break;
          single = 1'b1; tick(); single = 1'b0; tick(); tick();
          cur = life_next(cur);
          n_checks++; if (alive !== cur) $display("FAIL rnd%0d_sgl%0d got %h want %h", it, k, alive, cur); else n_pass++;
        end
      end
      n_checks++; if (halted !== 1'b1 || halt_cause !== cause || gen_count !== gens[7:0] || alive !== fin) $display("FAIL rnd%0d seed=%h got h=%b c=%b gen=%0d alive=%h want 1/%b/%0d/%h", it, seed, halted, halt_cause, gen_count, alive, cause, gens, fin); else n_pass++;
    end
  endtask

  task automatic test_reset_midstep();
    bit to; int s0;
    do_load(16'h0070);
    run = 1'b1;
    to = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (step && gen_count == 8'd1) begin to = 1'b0; break; end
    end
    reset = 1'b0; #1;
    n_checks++; if (to) $display("FAIL rm_timeout got no 2nd step want step"); else n_pass++;
    n_checks++; if (step !== 1'b0 || write_enb !== 1'b0 || gen_count !== 8'd0 || val !== 16'h0) $display("FAIL rm_abort got st=%b we=%b gen=%0d val=%h want 0/0/0/0", step, write_enb, gen_count, val); else n_pass++;
    run = 1'b0;
    tick(); reset = 1'b1;
    s0 = step_times.size();
    repeat (3) tick();
    n_checks++; if (load_ready !== 1'b1 || busy !== 1'b0 || halted !== 1'b0 || step_times.size() !== s0) $display("FAIL rm_idle got ready=%b busy=%b h=%b steps+=%0d want 1/0/0/0", load_ready, busy, halted, step_times.size() - s0); else n_pass++;
  endtask

  task automatic test_pulse_rules();
    n_checks++; if (adj_viol !== 0) $display("FAIL adj_step got %0d want 0", adj_viol); else n_pass++;
    n_checks++; if (both_viol !== 0) $display("FAIL we_and_step got %0d want 0", both_viol); else n_pass++;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; load_valid = 1'b0; load_data = '0; run = 1'b0; single = 1'b0; stop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_load_extinct();
    test_single_blinker();
    test_still_life();
    test_max_gen();
    test_run_stop();
    test_busy_ignore();
    test_run_single_together();
    test_random();
    test_pulse_rules();
    test_reset_midstep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
